airlock_sequencer: RTL and testbench

AIRLOCK_SEQUENCER -- requirements
Module: airlock_sequencer

---
 rtl/airlock_pkg.sv | 23 ++
 rtl/airlock_timer.sv | 34 +++
 rtl/airlock_sequencer.sv | 171 +++++++++++++++++
 tb/tb_airlock_sequencer.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/airlock_pkg.sv
// Shared definitions for the airlock sequencer: command codes, FSM state
// encoding and default chamber timing.
package airlock_pkg;

  localparam logic [2:0] CMD_NOP         = 3'd0;
  localparam logic [2:0] CMD_OPEN_OUTER  = 3'd1;
  localparam logic [2:0] CMD_CLOSE_OUTER = 3'd2;
  localparam logic [2:0] CMD_OPEN_INNER  = 3'd3;
  localparam logic [2:0] CMD_CLOSE_INNER = 3'd4;
  localparam logic [2:0] CMD_PRESSURIZE  = 3'd5;
  localparam logic [2:0] CMD_EVACUATE    = 3'd6;
  localparam logic [2:0] CMD_ABORT       = 3'd7;

  localparam int DEF_FILL_CYCLES = 7;
  localparam int DEF_EVAC_CYCLES = 5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_EVAC = 2'd2
  } state_t;

endpackage

// File: rtl/airlock_timer.sv
// 4-bit countdown used for fill/evacuate timing; the count register itself
// drives the Remaining output, so it is already registered.
module airlock_timer (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       load,
  input  logic [3:0] load_val,
  input  logic       dec,
  input  logic       clear,
  output logic [3:0] count,
  output logic       zero
);

  logic [3:0] count_r;

  // Countdown register: clear beats load beats decrement; saturates at zero.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      count_r <= 4'd0;
    end else if (clear) begin
      count_r <= 4'd0;
    end else if (load) begin
      count_r <= load_val;
    end else if (dec && (count_r != 4'd0)) begin
      count_r <= count_r - 4'd1;
    end else begin
      count_r <= count_r;
    end
  end

  assign count = count_r;
  assign zero  = (count_r == 4'd0);

endmodule

// File: rtl/airlock_sequencer.sv
// Airlock door/pressure sequencer: enforces the door interlocks, times the
// fill and evacuate phases, and reports each accepted command with Done/Reject.
module airlock_sequencer
  import airlock_pkg::*;
#(
  parameter int FILL_CYCLES = DEF_FILL_CYCLES,
  parameter int EVAC_CYCLES = DEF_EVAC_CYCLES
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       CmdValid,
  input  logic [2:0] Cmd,
  output logic       CmdReady,
  output logic       Done,
  output logic       Reject,
  output logic       OuterOpen,
  output logic       InnerOpen,
  output logic       Pressurized,
  output logic       Busy,
  output logic [3:0] Remaining
);

  localparam logic [3:0] FILL_LOAD = 4'(FILL_CYCLES - 1);
  localparam logic [3:0] EVAC_LOAD = 4'(EVAC_CYCLES - 1);

  state_t     state_r, state_s;
  logic       outer_r, outer_s;
  logic       inner_r, inner_s;
  logic       press_r, press_s;
  logic       done_r, done_s;
  logic       reject_r, reject_s;
  logic       busy_r;
  logic       cmd_ready_r;
  logic       accept_s;
  logic       load_s, dec_s, clear_s, zero_s;
  logic [3:0] load_val_s;
  logic [3:0] remaining_s;

  airlock_timer u_timer (
    .clk      (Clock),
    .reset_n  (Reset),
    .load     (load_s),
    .load_val (load_val_s),
    .dec      (dec_s),
    .clear    (clear_s),
    .count    (remaining_s),
    .zero     (zero_s)
  );

  assign accept_s = CmdValid && cmd_ready_r;

  // Next-state, interlock decisions and pulse generation.
  always_comb begin
    state_s    = state_r;
    outer_s    = outer_r;
    inner_s    = inner_r;
    press_s    = press_r;
    done_s     = 1'b0;
    reject_s   = 1'b0;
    load_s     = 1'b0;
    load_val_s = 4'd0;
    dec_s      = 1'b0;
    clear_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          case (Cmd)
            CMD_OPEN_OUTER: begin
              if (!inner_r && !press_r) begin
                outer_s = 1'b1;
                done_s  = 1'b1;
              end else begin
                reject_s = 1'b1;
              end
            end
            CMD_CLOSE_OUTER: begin
              outer_s = 1'b0;
              done_s  = 1'b1;
            end
            CMD_OPEN_INNER: begin
              if (!outer_r && press_r) begin
                inner_s = 1'b1;
                done_s  = 1'b1;
              end else begin
                reject_s = 1'b1;
              end
            end
            CMD_CLOSE_INNER: begin
              inner_s = 1'b0;
              done_s  = 1'b1;
            end
            CMD_PRESSURIZE: begin
              if (!outer_r && !inner_r && !press_r) begin
                state_s    = ST_FILL;
                load_s     = 1'b1;
                load_val_s = FILL_LOAD;
              end else begin
                reject_s = 1'b1;
              end
            end
            CMD_EVACUATE: begin
              if (!outer_r && !inner_r && press_r) begin
                state_s    = ST_EVAC;
                load_s     = 1'b1;
                load_val_s = EVAC_LOAD;
              end else begin
                reject_s = 1'b1;
              end
            end
            default: begin
              state_s = state_r;
            end
          endcase
        end else begin
          state_s = state_r;
        end
      end
      ST_FILL, ST_EVAC: begin
        // ABORT bypasses CmdReady and wins over a completing countdown.
        if (CmdValid && (Cmd == CMD_ABORT)) begin
          state_s  = ST_IDLE;
          reject_s = 1'b1;
          clear_s  = 1'b1;
        end else if (zero_s) begin
          state_s = ST_IDLE;
          press_s = ~press_r;
          done_s  = 1'b1;
        end else begin
          dec_s = 1'b1;
        end
      end
      default: begin
        state_s = ST_IDLE;
        clear_s = 1'b1;
      end
    endcase
  end

  // Register state, door/pressure flags and status outputs.
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      state_r     <= ST_IDLE;
      outer_r     <= 1'b0;
      inner_r     <= 1'b0;
      press_r     <= 1'b0;
      done_r      <= 1'b0;
      reject_r    <= 1'b0;
      busy_r      <= 1'b0;
      cmd_ready_r <= 1'b0;
    end else begin
      state_r     <= state_s;
      outer_r     <= outer_s;
      inner_r     <= inner_s;
      press_r     <= press_s;
      done_r      <= done_s;
      reject_r    <= reject_s;
      busy_r      <= (state_s != ST_IDLE);
      cmd_ready_r <= (state_s == ST_IDLE);
    end
  end

  assign CmdReady    = cmd_ready_r;
  assign Done        = done_r;
  assign Reject      = reject_r;
  assign OuterOpen   = outer_r;
  assign InnerOpen   = inner_r;
  assign Pressurized = press_r;
  assign Busy        = busy_r;
  assign Remaining   = remaining_s;

endmodule

// File: tb/tb_airlock_sequencer.sv
// Scoreboard bench for airlock_sequencer: expected Done/Reject pulses are
// queued with their due cycle when a command is driven, and matched on output.
module tb_airlock_sequencer;
  import airlock_pkg::*;

  logic       Clock = 1'b0;
  logic       Reset;
  logic       CmdValid;
  logic [2:0] Cmd;
  logic       CmdReady, Done, Reject, OuterOpen, InnerOpen, Pressurized, Busy;
  logic [3:0] Remaining;

  localparam logic [1:0] P_DONE = 2'b10;
  localparam logic [1:0] P_REJ  = 2'b01;

  typedef struct {
    logic [1:0] kind;
    int         due;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_err = 0;

  airlock_sequencer dut (
    .Clock       (Clock),
    .Reset       (Reset),
    .CmdValid    (CmdValid),
    .Cmd         (Cmd),
    .CmdReady    (CmdReady),
    .Done        (Done),
    .Reject      (Reject),
    .OuterOpen   (OuterOpen),
    .InnerOpen   (InnerOpen),
    .Pressurized (Pressurized),
    .Busy        (Busy),
    .Remaining   (Remaining)
  );

  always #5 Clock = ~Clock;

  always @(posedge Clock) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic send(input logic [2:0] c, input logic [1:0] k, input int lat);
    CmdValid = 1'b1;
    Cmd      = c;
    if (k != 2'b00) sb.push_back('{kind: k, due: cyc + lat});
    tick();
    CmdValid = 1'b0;
    Cmd      = 3'd0;
  endtask

  // Pulse monitor: every Done/Reject must match the oldest expectation and its cycle.
  always @(negedge Clock) begin : mon
    exp_t e;
    if (Done || Reject) begin
      if (sb.size() == 0) begin
        check_eq("unexp_pulse", {Done, Reject}, 0);
      end else begin
        e = sb.pop_front();
        check_eq("pulse_kind", {Done, Reject}, e.kind);
        check_eq("pulse_cycle", cyc, e.due);
      end
    end else if (sb.size() > 0 && cyc > sb[0].due) begin
      check_eq("pulse_missing", cyc, sb[0].due);
      e = sb.pop_front();
    end
  end

  initial begin
    Reset = 1'b0; CmdValid = 1'b0; Cmd = 3'd0;
    repeat (2) tick();
    check_eq("rst_outer", OuterOpen, 0);
    check_eq("rst_inner", InnerOpen, 0);
    check_eq("rst_press", Pressurized, 0);
    check_eq("rst_busy", Busy, 0);
    check_eq("rst_pulses", {Done, Reject}, 0);
    check_eq("rst_rem", Remaining, 0);
    Reset = 1'b1;
    tick();
    check_eq("rdy_after_rst", CmdReady, 1);

    // Door interlocks while unpressurized
    send(CMD_OPEN_INNER, P_REJ, 1);
    check_eq("inner_stays_closed", InnerOpen, 0);
    send(CMD_OPEN_OUTER, P_DONE, 1);
    check_eq("outer_opened", OuterOpen, 1);
    send(CMD_OPEN_OUTER, P_DONE, 1);
    check_eq("outer_still_open", OuterOpen, 1);
    send(CMD_PRESSURIZE, P_REJ, 1);
    check_eq("press_rej_busy", Busy, 0);
    send(CMD_CLOSE_OUTER, P_DONE, 1);
    check_eq("outer_closed", OuterOpen, 0);

    // Full fill with a dropped command in the middle
    send(CMD_PRESSURIZE, P_DONE, DEF_FILL_CYCLES + 1);
    check_eq("fill_busy", Busy, 1);
    check_eq("fill_rem_start", Remaining, DEF_FILL_CYCLES - 1);
    check_eq("fill_not_ready", CmdReady, 0);
    for (int r = DEF_FILL_CYCLES - 2; r >= 0; r--) begin
      if (r == 4) begin
        CmdValid = 1'b1;
        Cmd      = CMD_CLOSE_OUTER;
      end
      tick();
      CmdValid = 1'b0;
      Cmd      = 3'd0;
      check_eq("fill_rem", Remaining, r);
    end
    tick();
    check_eq("fill_press", Pressurized, 1);
    check_eq("fill_idle", Busy, 0);
    check_eq("fill_ready", CmdReady, 1);

    // Interlocks while pressurized
    send(CMD_OPEN_OUTER, P_REJ, 1);
    check_eq("outer_rej", OuterOpen, 0);
    send(CMD_OPEN_INNER, P_DONE, 1);
    check_eq("inner_opened", InnerOpen, 1);
    send(CMD_EVACUATE, P_REJ, 1);
    check_eq("evac_rej_busy", Busy, 0);
    send(CMD_CLOSE_INNER, P_DONE, 1);
    check_eq("inner_closed", InnerOpen, 0);

    // Abort mid-evacuate at Remaining=2
    send(CMD_EVACUATE, 2'b00, 0);
    check_eq("evac_rem_start", Remaining, DEF_EVAC_CYCLES - 1);
    repeat (2) tick();
    check_eq("evac_rem_2", Remaining, 2);
    send(CMD_ABORT, P_REJ, 1);
    check_eq("abort_press", Pressurized, 1);
    check_eq("abort_rem", Remaining, 0);
    check_eq("abort_ready", CmdReady, 1);
    check_eq("abort_busy", Busy, 0);

    // ABORT in IDLE and NOP are ignored
    send(CMD_ABORT, 2'b00, 0);
    send(CMD_NOP, 2'b00, 0);
    tick();
    check_eq("idle_abort_press", Pressurized, 1);
    check_eq("idle_abort_busy", Busy, 0);

    // ABORT coinciding with Remaining=0 wins over completion
    send(CMD_EVACUATE, 2'b00, 0);
    repeat (DEF_EVAC_CYCLES - 1) tick();
    check_eq("evac_rem_0", Remaining, 0);
    send(CMD_ABORT, P_REJ, 1);
    check_eq("abort0_press", Pressurized, 1);

    // Complete evacuation
    send(CMD_EVACUATE, P_DONE, DEF_EVAC_CYCLES + 1);
    repeat (DEF_EVAC_CYCLES) tick();
    check_eq("evac_press", Pressurized, 0);
    check_eq("evac_ready", CmdReady, 1);

    // Reset mid-fill abandons the operation silently
    send(CMD_PRESSURIZE, 2'b00, 0);
    repeat (3) tick();
    check_eq("fill_rem_3", Remaining, 3);
    Reset = 1'b0;
    sb.delete();
    tick();
    check_eq("mrst_busy", Busy, 0);
    check_eq("mrst_rem", Remaining, 0);
    check_eq("mrst_press", Pressurized, 0);
    check_eq("mrst_doors", {OuterOpen, InnerOpen}, 0);
    check_eq("mrst_pulses", {Done, Reject}, 0);
    Reset = 1'b1;
    repeat (DEF_FILL_CYCLES + 2) tick();
    check_eq("mrst_ready", CmdReady, 1);
    check_eq("mrst_press_after", Pressurized, 0);
    check_eq("sb_drained", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
